aes_stream_loader: RTL

Word-serial front/back end for the AES cipher core. Assembles 32-bit input words into the 128-bit `Key` and `Plain_Text` buses and pulses `Start`, waits for `Done`, then captures `Cipher_Text` and returns it as four 32-bit words. Sits directly between the system word bus and the cipher core, owning all sequencing around the core.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_stream_loader_if.sv | 23 ++
 rtl/aes_word_serializer.sv | 46 ++++
 rtl/aes_stream_loader.sv | 132 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM state and word-index types for the AES stream loader.
// word_of() is the one place that defines MSB-first word order inside a 128-bit sentence.
package aes_pkg;

    localparam int BYTE     = 8;
    localparam int WORD     = 32;
    localparam int SENTENCE = 128;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        DRAIN
    } state_t;

    typedef logic [1:0] word_idx_t;

    // Word 0 is [127:96], word 3 is [31:0].
    function automatic logic [WORD-1:0] word_of(input logic [SENTENCE-1:0] s,
                                                input word_idx_t         idx);
        return s[SENTENCE-1 - int'(idx)*WORD -: WORD];
    endfunction

endpackage

// File: rtl/aes_stream_loader_if.sv
// Word-bus side of the loader: input word stream and output word stream.
// The master is the system bus; the slave is the loader.
interface aes_stream_loader_if;

    logic                     In_Valid;
    logic                     In_Ready;
    logic [aes_pkg::WORD-1:0] In_Data;
    logic                     In_Is_Key;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic [aes_pkg::WORD-1:0] Out_Data;

    modport master (
        output In_Valid, In_Data, In_Is_Key, Out_Ready,
        input  In_Ready, Out_Valid, Out_Data
    );

    modport slave (
        input  In_Valid, In_Data, In_Is_Key, Out_Ready,
        output In_Ready, Out_Valid, Out_Data
    );

endinterface

// File: rtl/aes_word_serializer.sv
// Captures a 128-bit result on a load strobe and hands it out as four 32-bit words,
// MSB word first, holding each word until the downstream accepts it.
module aes_word_serializer
    import aes_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_load,
    input  logic [SENTENCE-1:0] i_data,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [WORD-1:0]     o_data,
    output logic                o_last
);

    logic [SENTENCE-1:0] r_capture;
    word_idx_t           r_idx;
    logic                r_valid;
    logic [WORD-1:0]     r_data;

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_valid & i_ready & (r_idx == 2'd3);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_capture <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else if (i_load) begin
            r_capture <= i_data;
            r_idx     <= '0;
            r_valid   <= 1'b1;
            r_data    <= word_of(i_data, 2'd0);
        end else if (r_valid && i_ready) begin
            if (r_idx == 2'd3) begin
                r_valid <= 1'b0;
            end else begin
                r_idx  <= r_idx + 2'd1;
                r_data <= word_of(r_capture, r_idx + 2'd1);
            end
        end
    end

endmodule

// File: rtl/aes_stream_loader.sv
// Word-serial front/back end for the AES core: assembles key and text, pulses Start,
// waits for Done with a timeout, then streams the cipher text out through the serializer.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                RST,
    aes_stream_loader_if.slave  bus,
    output logic [SENTENCE-1:0] Key,
    output logic [SENTENCE-1:0] Plain_Text,
    output logic                Start,
    input  logic                Done,
    input  logic [SENTENCE-1:0] Cipher_Text,
    output logic                Err
);

    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [2:0]     TXT_FULL = 3'd4;

    state_t              r_state;
    logic [SENTENCE-1:0] r_key;
    logic [SENTENCE-1:0] r_text;
    word_idx_t           r_key_cnt;
    logic [2:0]          r_txt_cnt;
    logic                r_key_ok;
    logic                r_start;
    logic                r_err;
    logic [TW-1:0]       r_tcnt;

    logic       w_accept;
    logic       w_key_wr;
    logic       w_txt_wr;
    word_idx_t  w_key_idx;
    logic       w_key_ok_nxt;
    logic [2:0] w_txt_cnt_nxt;
    logic       w_load;
    logic       w_last;

    assign bus.In_Ready = (r_state == LOAD);
    assign w_accept     = bus.In_Valid & bus.In_Ready;
    assign w_key_wr     = w_accept & bus.In_Is_Key;
    assign w_txt_wr     = w_accept & ~bus.In_Is_Key & (r_txt_cnt != TXT_FULL);
    // A key word arriving over a complete key begins a fresh key at word 0.
    assign w_key_idx    = r_key_ok ? 2'd0 : r_key_cnt;
    assign w_load       = (r_state == WAIT) & Done;

    assign Key        = r_key;
    assign Plain_Text = r_text;
    assign Start      = r_start;
    assign Err        = r_err;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_key_ok_nxt  = r_key_ok;
        w_txt_cnt_nxt = r_txt_cnt;
        if (w_key_wr) w_key_ok_nxt = (w_key_idx == 2'd3);
        if (w_txt_wr) w_txt_cnt_nxt = r_txt_cnt + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the wide key/text registers are reset too, so nothing from an aborted block survives RST.
            r_state   <= LOAD;
            r_key     <= '0;
            r_text    <= '0;
            r_key_cnt <= '0;
            r_txt_cnt <= '0;
            r_key_ok  <= 1'b0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_key_wr) begin
                        r_key[SENTENCE-1 - int'(w_key_idx)*WORD -: WORD] <= bus.In_Data;
                        r_key_cnt <= w_key_idx + 2'd1;
                    end
                    if (w_txt_wr) begin
                        r_text[SENTENCE-1 - int'(r_txt_cnt[1:0])*WORD -: WORD] <= bus.In_Data;
                    end
                    r_key_ok  <= w_key_ok_nxt;
                    r_txt_cnt <= w_txt_cnt_nxt;
                    // Launch on the post-accept counts so Start follows the last word by one cycle.
                    if (w_key_ok_nxt && (w_txt_cnt_nxt == TXT_FULL)) begin
                        r_state <= START;
                        r_start <= 1'b1;
                    end
                end
                START: begin
                    r_state <= WAIT;
                    r_tcnt  <= '0;
                end
                WAIT: begin
                    if (Done) begin
                        r_state <= DRAIN;
                    end else if (r_tcnt == T_LAST) begin
                        r_err     <= 1'b1;
                        r_txt_cnt <= '0;
                        r_state   <= LOAD;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_last) begin
                        r_txt_cnt <= '0;
                        r_state   <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    aes_word_serializer u_serializer (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_load),
        .i_data  (Cipher_Text),
        .i_ready (bus.Out_Ready),
        .o_valid (bus.Out_Valid),
        .o_data  (bus.Out_Data),
        .o_last  (w_last)
    );

endmodule
